// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the 2-input gate truth-table sequencer.
package gate_seq_pkg;

    // Sequencer states, kept as plain constants for compatibility with older tooling.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRIVE  = 3'd1;
    localparam state_t ST_SAMPLE = 3'd2;
    localparam state_t ST_REPORT = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Test vector index, packed as {A,B}.
    typedef logic [1:0] vec_t;

    // Expected {xnor, nand, and} for each vector, indexed by {A,B}.
    localparam logic [2:0] EXPECT_TT [4] = '{3'b110, 3'b010, 3'b010, 3'b101};

endpackage

// File: rtl/gate_expect_lut.sv
// Expected-output lookup: maps a {A,B} vector to the {xnor, nand, and} truth-table value.
module gate_expect_lut
    import gate_seq_pkg::*;
(
    input  vec_t       vec,
    output logic [2:0] expected
);

    assign expected = EXPECT_TT[vec];

endmodule

// File: rtl/gate_truth_sequencer.sv
// Gate truth-table sequencer: drives A/B through 00,01,10,11, samples the three
// gate outputs after a settle window and streams one record per vector over a
// valid/ready port.
// Optional checking: define GATE_SEQ_CHECK_EN to compare each record against the
// expected truth table and count mismatches; otherwise res_err/err_count are 0.
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned REPEAT      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_and,
    input  logic       y_nand,
    input  logic       y_xnor,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [1:0] res_vec,
    output logic [2:0] res_y,
    output logic       res_err,
    output logic [7:0] err_count,
    output logic       done
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] PASS_LAST = 8'(REPEAT - 1);

    state_t     state;
    vec_t       vec;
    logic [7:0] hold_cnt;
    logic [7:0] pass_cnt;
    logic [2:0] y_now;
    logic       handshake;

    assign y_now     = {y_xnor, y_nand, y_and};
    assign handshake = res_valid && res_ready;

    // Sequencer FSM with vector, hold and pass counters; captures the record in SAMPLE.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (!rst_n) begin
            state    <= ST_IDLE;
            vec      <= '0;
            hold_cnt <= '0;
            pass_cnt <= '0;
            res_vec  <= '0;
            res_y    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_DRIVE;
                        vec      <= '0;
                        pass_cnt <= '0;
                        hold_cnt <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= ST_SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    res_y   <= y_now;
                    res_vec <= vec;
                    state   <= ST_REPORT;
                end
                ST_REPORT: begin
                    // Record fields stay frozen until the consumer accepts them.
                    if (handshake) begin
                        if (vec != 2'd3) begin
                            vec   <= vec + 2'd1;
                            state <= ST_DRIVE;
                        end else if (pass_cnt < PASS_LAST) begin
                            vec      <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                            state    <= ST_DRIVE;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gate inputs follow the current vector while a vector is active, else idle low.
    always_comb begin
        // NOTE: outputs get a default before the case so no path leaves them unassigned
        // (which would infer a latch).
        a_out = 1'b0;
        b_out = 1'b0;
        case (state)
            ST_DRIVE, ST_SAMPLE, ST_REPORT: {a_out, b_out} = vec;
            default: ;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_REPORT);
    assign done      = (state == ST_DONE);

`ifdef GATE_SEQ_CHECK_EN
    logic [2:0] expected;
    logic       mismatch;

    gate_expect_lut u_expect_lut (
        .vec      (vec),
        .expected (expected)
    );

    assign mismatch = (y_now != expected);

    // Mismatch flag per record and saturating per-run mismatch count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_err   <= 1'b0;
            err_count <= '0;
        end else if (state == ST_IDLE && start) begin
            err_count <= '0;
        end else if (state == ST_SAMPLE) begin
            res_err <= mismatch;
            if (mismatch && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign res_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Self-checking bench for gate_truth_sequencer. Two instances (HOLD=1/REPEAT=1 and
// HOLD=3/REPEAT=2) are driven from shared stimulus; sel picks the one under test.
// Gate cells are modelled inline, with an optional nand stuck-at-0 fault.
module tb_gate_truth_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic res_ready;
    logic fault_nand;
    int   sel;

    logic [1:0] start_w, busy_w, a_w, b_w, valid_w, err_w, done_w;
    logic [1:0] yand_w, ynand_w, yxnor_w;
    logic [1:0] vec_w [2];
    logic [2:0] y_w   [2];
    logic [7:0] cnt_w [2];

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    assign start_w[0] = start && (sel == 0);
    assign start_w[1] = start && (sel == 1);

    // Gate cells under test.
    assign yand_w  = a_w & b_w;
    assign ynand_w = fault_nand ? 2'b00 : ~(a_w & b_w);
    assign yxnor_w = ~(a_w ^ b_w);

    gate_truth_sequencer #(.HOLD_CYCLES(1), .REPEAT(1)) u_dut_short (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_w[0]),
        .busy      (busy_w[0]),
        .a_out     (a_w[0]),
        .b_out     (b_w[0]),
        .y_and     (yand_w[0]),
        .y_nand    (ynand_w[0]),
        .y_xnor    (yxnor_w[0]),
        .res_valid (valid_w[0]),
        .res_ready (res_ready),
        .res_vec   (vec_w[0]),
        .res_y     (y_w[0]),
        .res_err   (err_w[0]),
        .err_count (cnt_w[0]),
        .done      (done_w[0])
    );

    gate_truth_sequencer #(.HOLD_CYCLES(3), .REPEAT(2)) u_dut_long (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_w[1]),
        .busy      (busy_w[1]),
        .a_out     (a_w[1]),
        .b_out     (b_w[1]),
        .y_and     (yand_w[1]),
        .y_nand    (ynand_w[1]),
        .y_xnor    (yxnor_w[1]),
        .res_valid (valid_w[1]),
        .res_ready (res_ready),
        .res_vec   (vec_w[1]),
        .res_y     (y_w[1]),
        .res_err   (err_w[1]),
        .err_count (cnt_w[1]),
        .done      (done_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are inspected on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (done_w[sel]) done_seen++;
    endtask

    // One complete run on the selected instance, checked against a vector-list model.
    // mode 0: ready always; 1: random stalls; 2: five-cycle stall on vector 2 of pass 0.
    task automatic run(input string tag, input int mode, input bit keep_start);
        int hold;
        int rep;
        int exp_q[$];
        int errs;
        int n;
        int stall;
        int v;
        logic ea, eb;
        logic [2:0] exp_y, exp_tt;
        logic exp_err;
        logic [1:0] hv;
        logic [2:0] hy;

        hold = (sel == 1) ? 3 : 1;
        rep  = (sel == 1) ? 2 : 1;
        errs = 0;
        for (int p = 0; p < rep; p++)
            for (int k = 0; k < 4; k++) exp_q.push_back(k);
        done_seen = 0;

        start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;

        for (int i = 0; i < exp_q.size(); i++) begin
            v  = exp_q[i];
            ea = v[1];
            eb = v[0];
            exp_tt = {~(ea ^ eb), ~(ea & eb), ea & eb};
            exp_y  = {~(ea ^ eb), fault_nand ? 1'b0 : ~(ea & eb), ea & eb};
`ifdef GATE_SEQ_CHECK_EN
            exp_err = (exp_y != exp_tt);
`else
            exp_err = 1'b0;
`endif
            if (exp_err) errs++;

            n = 0;
            while (!valid_w[sel] && n < 200) begin
                tick();
                n++;
            end
            // n counts edges since the reference edge; valid is sampled high one edge later.
            chk($sformatf("%s latency rec%0d", tag, i), n + 1, hold + 2);
            if (!valid_w[sel]) return;
            chk($sformatf("%s vec rec%0d", tag, i), vec_w[sel], v);
            chk($sformatf("%s y rec%0d", tag, i), y_w[sel], exp_y);
            chk($sformatf("%s err rec%0d", tag, i), err_w[sel], exp_err);
            chk($sformatf("%s ab rec%0d", tag, i), {a_w[sel], b_w[sel]}, v);

            if (mode == 2 && v == 2 && i < 4) stall = 5;
            else if (mode == 1) stall = $urandom_range(0, 3);
            else stall = 0;

            hv = vec_w[sel];
            hy = y_w[sel];
            res_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk($sformatf("%s stall valid rec%0d", tag, i), valid_w[sel], 1'b1);
                chk($sformatf("%s stall vec rec%0d", tag, i), vec_w[sel], hv);
                chk($sformatf("%s stall y rec%0d", tag, i), y_w[sel], hy);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk($sformatf("%s valid drop rec%0d", tag, i), valid_w[sel], 1'b0);
            if (i + 1 < exp_q.size()) begin
                chk($sformatf("%s next ab rec%0d", tag, i), {a_w[sel], b_w[sel]}, exp_q[i + 1]);
            end else begin
                chk($sformatf("%s done", tag), done_w[sel], 1'b1);
                chk($sformatf("%s err_count", tag), cnt_w[sel], (errs > 255) ? 255 : errs);
            end
        end

        tick();
        chk($sformatf("%s done low", tag), done_w[sel], 1'b0);
        chk($sformatf("%s busy after", tag), busy_w[sel], 1'b0);
        chk($sformatf("%s err_count held", tag), cnt_w[sel], (errs > 255) ? 255 : errs);
        if (keep_start) begin
            tick();
            chk($sformatf("%s restart busy", tag), busy_w[sel], 1'b1);
            chk($sformatf("%s restart ab", tag), {a_w[sel], b_w[sel]}, 2'b00);
            start = 1'b0;
        end
        chk($sformatf("%s done pulses", tag), done_seen, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        res_ready  = 1'b0;
        fault_nand = 1'b0;
        sel        = 0;
        @(negedge clk);
        tick();
        tick();

        // Reset state of both instances.
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset busy%0d", s), busy_w[s], 1'b0);
            chk($sformatf("reset valid%0d", s), valid_w[s], 1'b0);
            chk($sformatf("reset done%0d", s), done_w[s], 1'b0);
            chk($sformatf("reset ab%0d", s), {a_w[s], b_w[s]}, 2'b00);
            chk($sformatf("reset rec%0d", s), {vec_w[s], y_w[s], err_w[s]}, 0);
            chk($sformatf("reset cnt%0d", s), cnt_w[s], 0);
        end
        rst_n = 1'b1;
        tick();

        // Basic pass, backpressure, stuck-at nand, random consumer stalls.
        run("basic", 0, 1'b0);
        run("stall", 2, 1'b0);
        fault_nand = 1'b1;
        run("fault", 0, 1'b0);
        run("fault_rnd", 1, 1'b0);
        fault_nand = 1'b0;
        for (int r = 0; r < 3; r++) run($sformatf("rnd%0d", r), 1, 1'b0);

        // Longer hold and two passes.
        sel = 1;
        run("long", 0, 1'b0);
        run("long_rnd", 1, 1'b0);
        sel = 0;

        // Reset while a record is pending, then a clean restart.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!valid_w[0] && n < 50) begin
            tick();
            n++;
        end
        chk("midrst reached report", valid_w[0], 1'b1);
        rst_n = 1'b0;
        tick();
        chk("midrst busy", busy_w[0], 1'b0);
        chk("midrst valid", valid_w[0], 1'b0);
        chk("midrst ab", {a_w[0], b_w[0]}, 2'b00);
        rst_n = 1'b1;
        tick();
        run("after_rst", 0, 1'b0);

        // start held high through a whole run.
        run("held", 0, 1'b1);
        do_reset();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
